gcd_requester: RTL and testbench
================================

# gcd_requester

Initiator for the GCD engine's start/done handshake. It accepts operand pairs from an upstream valid/ready source, buffers up to two pairs, and issues each pair to the engine with a one-cycle start pulse. It captures the engine's result on done and presents it downstream on a valid/ready result port. It also handles zero operands locally, because the engine does not terminate on zero inputs. A watchdog recovers a hung engine.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must match the engine.
- TIMEOUT, 1023, maximum WAIT cycles before the watchdog fires; must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  upstream operand pair valid.
- req_ready  out  1  buffer not full; equals !full; never depends on a same-cycle pop.
- req_a, req_b  in  WIDTH  operands.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_in1, eng_in2  out  WIDTH  operands to the engine; registered; stable from the start cycle until the request completes.
- eng_reset  out  1  engine reset, registered.
- eng_gcd  in  WIDTH  engine result; valid in the eng_done cycle.
- eng_done  in  1  engine completion.
- res_valid  out  1  result held.
- res_ready  in  1  downstream accept.
- res_gcd  out  WIDTH  result value.
- res_timeout  out  1  result produced by the watchdog; res_gcd is 0 in that case.

## Operation
- Request buffer: 2-entry FIFO.
  - A push occurs on req_valid && req_ready.
  - A pop occurs only in IDLE when the state machine takes the head entry.
  - Entries leave in arrival order.
- State machine: IDLE, START, WAIT, RECOVER, GAP.
- IDLE: acts only when the FIFO is non-empty and res_valid == 0.
  - If head a == 0 or b == 0 (zero bypass): res_gcd ← a | b, res_timeout ← 0, res_valid ← 1. Pop the head and stay in IDLE. The engine is not touched. (0,0) yields 0.
  - Otherwise: eng_in1 ← a, eng_in2 ← b. Pop the head and go to START.
- START: eng_start = 1 for exactly this cycle. Clear the watchdog counter and go to WAIT.
- WAIT: the counter increments each cycle.
  - If eng_done: res_gcd ← eng_gcd, res_timeout ← 0, res_valid ← 1. Go to GAP.
  - Else if the counter reaches TIMEOUT: res_gcd ← 0, res_timeout ← 1, res_valid ← 1. Go to RECOVER.
  - If eng_done and the limit occur in the same cycle, done wins.
- RECOVER: eng_reset = 1 for one cycle, then go to GAP.
- GAP: one idle cycle so the engine can return to its load state, then go to IDLE.
- Result register: res_valid clears on res_valid && res_ready. A new result can be written only when res_valid == 0, so there is never a write/consume collision.
- eng_done outside WAIT is ignored.
- Reset:
  - FIFO is emptied; state goes to IDLE.
  - res_valid = 0, res_gcd = 0, res_timeout = 0.
  - eng_start = 0, eng_in1 = eng_in2 = 0, counter = 0.
  - eng_reset resets to 1, so it is high for the first cycle after reset deasserts and then 0.
  - Reset mid-WAIT abandons the request; no result is produced for it.

## Timing
- Push at cycle T → head visible in IDLE at T+1 → eng_start high at T+2 (if res_valid == 0).
- Zero bypass: push at T → res_valid high at T+2.
- Engine path: eng_done at cycle D → res_valid high at D+1; earliest next eng_start is D+3.
- Watchdog: eng_start at S with no done → counter reaches TIMEOUT at S+TIMEOUT → res_valid and res_timeout at S+TIMEOUT+1; eng_reset high at S+TIMEOUT+1.
- req_ready is low whenever the FIFO holds 2 entries, including in a cycle where a pop occurs.
- Downstream back-pressure (res_valid && !res_ready) stalls issue; the FIFO keeps accepting until full.

## Test plan
- Basic request: (48,18) pushed into an idle block with a behavioural engine → one eng_start pulse with eng_in1=48, eng_in2=18 → res_gcd=6, res_timeout=0, one cycle after eng_done.
- Zero bypass: (0,35), then (0,0) → res_gcd=35, then res_gcd=0 → eng_start never asserts; each result valid 2 cycles after its push.
- Back-pressure: res_ready held low; push (12,8), (9,6), (7,7) →
  - the first result (4) is held;
  - the next two requests are queued;
  - req_ready drops after the third push is accepted;
  - after res_ready is released, results arrive 4, 3, 7 in order.
- Watchdog: TIMEOUT=8; engine never asserts done → res_valid with res_timeout=1 and res_gcd=0 nine cycles after eng_start → eng_reset pulses for 1 cycle → next queued request issues after GAP.
- Done-versus-timeout tie: eng_done arrives exactly in the TIMEOUT cycle → res_timeout=0, correct gcd, no eng_reset pulse.
- Reset mid-WAIT: reset asserted 3 cycles after eng_start with one entry queued → all outputs return to reset values, eng_reset high for the first post-reset cycle, no result emitted, FIFO empty (req_ready=1).

Source files
------------

// File: rtl/gcd_requester.sv
`timescale 1ns/1ps
// Small generic FIFO: registered storage, head entry always visible on pop_dat_o.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: full_o comes from the occupancy register only, never from a same-cycle pop.
module gcd_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_dat_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= ptr_next(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_next(rd_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

// GCD engine initiator: buffers two operand pairs, drives start/done, zero bypass, watchdog.
// Latency: push->eng_start 2 cycles; eng_done->res_valid 1 cycle; zero bypass push->result 2 cycles.
// Backpressure: req_ready = !full; a held result (res_valid && !res_ready) stalls issue.
module gcd_requester #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             eng_start_o,
    output logic [WIDTH-1:0] eng_in1_o,
    output logic [WIDTH-1:0] eng_in2_o,
    output logic             eng_reset_o,
    input  logic [WIDTH-1:0] eng_gcd_i,
    input  logic             eng_done_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_gcd_o,
    output logic             res_timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RECOVER,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0]     in1_q, in1_d, in2_q, in2_d;
    logic [WIDTH-1:0]     res_gcd_q, res_gcd_d;
    logic                 res_vld_q, res_vld_d;
    logic                 res_to_q, res_to_d;
    logic                 start_q, start_d;
    logic                 eng_rst_q, eng_rst_d;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [2*WIDTH-1:0]   head;
    logic [WIDTH-1:0]     head_a, head_b;

    gcd_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (2)
    ) u_req_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (req_valid_i && req_ready_o),
        .push_dat_i ({req_a_i, req_b_i}),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign req_ready_o = !fifo_full;
    assign head_a      = head[2*WIDTH-1:WIDTH];
    assign head_b      = head[WIDTH-1:0];
    assign cnt_inc     = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        res_vld_d = res_vld_q && !res_ready_i;
        res_gcd_d = res_gcd_q;
        res_to_d  = res_to_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !res_vld_q) begin
                    pop = 1'b1;
                    // The engine never terminates on a zero operand, so answer locally.
                    if (head_a == '0 || head_b == '0) begin
                        res_gcd_d = head_a | head_b;
                        res_to_d  = 1'b0;
                        res_vld_d = 1'b1;
                    end else begin
                        in1_d   = head_a;
                        in2_d   = head_b;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (eng_done_i) begin
                    res_gcd_d = eng_gcd_i;
                    res_to_d  = 1'b0;
                    res_vld_d = 1'b1;
                    state_d   = S_GAP;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    res_gcd_d = '0;
                    res_to_d  = 1'b1;
                    res_vld_d = 1'b1;
                    state_d   = S_RECOVER;
                end
            end
            S_RECOVER: state_d = S_GAP;
            S_GAP:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        start_d   = (state_d == S_START);
        eng_rst_d = (state_d == S_RECOVER);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            res_vld_q <= 1'b0;
            res_gcd_q <= '0;
            res_to_q  <= 1'b0;
            start_q   <= 1'b0;
            eng_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            res_vld_q <= res_vld_d;
            res_gcd_q <= res_gcd_d;
            res_to_q  <= res_to_d;
            start_q   <= start_d;
            eng_rst_q <= eng_rst_d;
        end
    end

    assign eng_start_o   = start_q;
    assign eng_in1_o     = in1_q;
    assign eng_in2_o     = in2_q;
    assign eng_reset_o   = eng_rst_q;
    assign res_valid_o   = res_vld_q;
    assign res_gcd_o     = res_gcd_q;
    assign res_timeout_o = res_to_q;
endmodule

// File: tb/tb_gcd_requester.sv
`timescale 1ns/1ps
// Bench for gcd_requester: directed scenarios plus randomized traffic against a queue-based model.
module tb_gcd_requester;
    localparam int W  = 16;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [W-1:0] req_a, req_b;
    logic         eng_start, eng_reset, eng_done;
    logic [W-1:0] eng_in1, eng_in2, eng_gcd;
    logic         res_valid, res_ready, res_timeout;
    logic [W-1:0] res_gcd;

    int checks   = 0;
    int failures = 0;

    // Behavioural engine: latency per start from lat_q, else eng_lat (0 = hang, <0 = random 1..7).
    int           eng_lat = 3;
    int           lat_q[$];
    bit           e_busy = 1'b0;
    int           e_rem;
    int           e_l;
    logic [W-1:0] e_res;

    always #5 clk = ~clk;

    gcd_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .eng_start_o   (eng_start),
        .eng_in1_o     (eng_in1),
        .eng_in2_o     (eng_in2),
        .eng_reset_o   (eng_reset),
        .eng_gcd_i     (eng_gcd),
        .eng_done_i    (eng_done),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_gcd_o     (res_gcd),
        .res_timeout_o (res_timeout)
    );

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int x, y, t;
        if (a == 0 || b == 0) return a | b;
        x = int'(a);
        y = int'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : engine
        eng_done = 1'b0;
        eng_gcd  = '0;
        forever begin
            @(posedge clk);
            #2;
            eng_done = 1'b0;
            if (reset || eng_reset) begin
                e_busy = 1'b0;
            end else if (e_busy) begin
                e_rem--;
                if (e_rem == 0) begin
                    eng_done = 1'b1;
                    eng_gcd  = e_res;
                    e_busy   = 1'b0;
                end
            end else if (eng_start) begin
                if (lat_q.size() > 0) e_l = lat_q.pop_front();
                else if (eng_lat < 0) e_l = int'($urandom_range(1, 7));
                else e_l = eng_lat;
                e_rem  = (e_l == 0) ? 32'h3fff_ffff : e_l;
                e_res  = ref_gcd(eng_in1, eng_in2);
                e_busy = 1'b1;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({res_valid, res_timeout, eng_start, eng_reset, req_ready} !== 5'b00011) begin
            failures++;
            $display("FAIL reset_flags: got vld=%b to=%b start=%b eng_rst=%b rdy=%b expected 0 0 0 1 1",
                     res_valid, res_timeout, eng_start, eng_reset, req_ready);
        end
        checks++;
        if ({res_gcd, eng_in1, eng_in2} !== '0) begin
            failures++;
            $display("FAIL reset_data: got gcd=%0d in1=%0d in2=%0d expected all 0", res_gcd, eng_in1, eng_in2);
        end
        tick();
        checks++;
        if (eng_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_eng_reset_drop: got %b expected 0", eng_reset);
        end
        tick();
    endtask

    task automatic test_basic();
        int n, starts;
        eng_lat   = 4;
        res_ready = 1'b1;
        repeat (3) tick();
        req_valid = 1'b1;
        req_a     = 16'd48;
        req_b     = 16'd18;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_req_ready: got %b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (eng_start !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_start: got %b expected 0", eng_start);
        end
        tick();
        checks++;
        if ({eng_start, eng_in1, eng_in2} !== {1'b1, 16'd48, 16'd18}) begin
            failures++;
            $display("FAIL basic_issue: got start=%b in1=%0d in2=%0d expected 1 48 18", eng_start, eng_in1, eng_in2);
        end
        n      = 0;
        starts = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (eng_start) starts++;
        end
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles start->result expected 5", n);
        end
        checks++;
        if ({res_gcd, res_timeout, eng_in1, eng_in2} !== {16'd6, 1'b0, 16'd48, 16'd18}) begin
            failures++;
            $display("FAIL basic_result: got gcd=%0d to=%b in1=%0d in2=%0d expected 6 0 48 18",
                     res_gcd, res_timeout, eng_in1, eng_in2);
        end
        checks++;
        if (starts !== 0) begin
            failures++;
            $display("FAIL basic_single_start: got %0d extra starts expected 0", starts);
        end
        repeat (3) tick();
    endtask

    task automatic test_zero_bypass();
        res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_valid = (c == 0 || c == 2);
            req_a     = '0;
            req_b     = (c == 0) ? 16'd35 : 16'd0;
            checks++;
            if ({res_valid, eng_start} !== {(c == 2 || c == 4), 1'b0}) begin
                failures++;
                $display("FAIL zb_ctl c=%0d: got vld=%b start=%b expected vld=%b start=0",
                         c, res_valid, eng_start, (c == 2 || c == 4));
            end
            if (c == 2 || c == 4) begin
                checks++;
                if ({res_gcd, res_timeout} !== {((c == 2) ? 16'd35 : 16'd0), 1'b0}) begin
                    failures++;
                    $display("FAIL zb_result c=%0d: got gcd=%0d to=%b expected %0d 0",
                             c, res_gcd, res_timeout, (c == 2) ? 35 : 0);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] exp_r [3];
        int got;
        exp_r     = '{16'd4, 16'd3, 16'd7};
        eng_lat   = 3;
        res_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            req_valid = (c < 3);
            req_a     = (c == 0) ? 16'd12 : (c == 1) ? 16'd9 : 16'd7;
            req_b     = (c == 0) ? 16'd8  : (c == 1) ? 16'd6 : 16'd7;
            checks++;
            if ({req_ready, res_valid, eng_start} !== {(c < 3), (c >= 6), (c == 2)}) begin
                failures++;
                $display("FAIL bp_ctl c=%0d: got rdy=%b vld=%b start=%b expected %b %b %b",
                         c, req_ready, res_valid, eng_start, (c < 3), (c >= 6), (c == 2));
            end
            if (c >= 6) begin
                checks++;
                if (res_gcd !== 16'd4) begin
                    failures++;
                    $display("FAIL bp_held c=%0d: got %0d expected 4", c, res_gcd);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        got       = 0;
        for (int n = 0; n < 60 && got < 3; n++) begin
            if (res_valid) begin
                checks++;
                if ({res_gcd, res_timeout} !== {exp_r[got], 1'b0}) begin
                    failures++;
                    $display("FAIL bp_order #%0d: got gcd=%0d to=%b expected %0d 0", got, res_gcd, res_timeout, exp_r[got]);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got !== 3) begin
            failures++;
            $display("FAIL bp_count: got %0d results expected 3", got);
        end
        repeat (3) tick();
    endtask

    task automatic test_watchdog();
        eng_lat   = 3;
        res_ready = 1'b1;
        lat_q.push_back(0);
        for (int c = 0; c < 25; c++) begin
            req_valid = (c < 2);
            req_a     = (c == 0) ? 16'd15 : 16'd21;
            req_b     = (c == 0) ? 16'd10 : 16'd14;
            checks++;
            if ({eng_start, eng_reset, res_valid} !== {(c == 2 || c == 14), (c == 11), (c == 11 || c == 18)}) begin
                failures++;
                $display("FAIL wd_ctl c=%0d: got start=%b eng_rst=%b vld=%b expected %b %b %b", c,
                         eng_start, eng_reset, res_valid, (c == 2 || c == 14), (c == 11), (c == 11 || c == 18));
            end
            if (c == 11 || c == 18) begin
                checks++;
                if ({res_gcd, res_timeout} !== ((c == 11) ? {16'd0, 1'b1} : {16'd7, 1'b0})) begin
                    failures++;
                    $display("FAIL wd_result c=%0d: got gcd=%0d to=%b expected %0d %0d",
                             c, res_gcd, res_timeout, (c == 11) ? 0 : 7, (c == 11) ? 1 : 0);
                end
            end
            if (c == 14) begin
                checks++;
                if ({eng_in1, eng_in2} !== {16'd21, 16'd14}) begin
                    failures++;
                    $display("FAIL wd_next_issue: got in1=%0d in2=%0d expected 21 14", eng_in1, eng_in2);
                end
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_tie();
        eng_lat   = TO;
        res_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            req_valid = (c == 0);
            req_a     = 16'd27;
            req_b     = 16'd18;
            checks++;
            if ({eng_start, eng_reset, res_valid} !== {(c == 2), 1'b0, (c == 11)}) begin
                failures++;
                $display("FAIL tie_ctl c=%0d: got start=%b eng_rst=%b vld=%b expected %b 0 %b",
                         c, eng_start, eng_reset, res_valid, (c == 2), (c == 11));
            end
            if (c == 11) begin
                checks++;
                if ({res_gcd, res_timeout} !== {16'd9, 1'b0}) begin
                    failures++;
                    $display("FAIL tie_result: got gcd=%0d to=%b expected 9 0", res_gcd, res_timeout);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        eng_lat   = 3;
    endtask

    task automatic test_reset_mid_wait();
        res_ready = 1'b1;
        lat_q.push_back(0);
        for (int c = 0; c < 21; c++) begin
            req_valid = (c < 2);
            req_a     = (c == 0) ? 16'd10 : 16'd6;
            req_b     = (c == 0) ? 16'd4  : 16'd3;
            reset     = (c == 5);
            if (c == 2) begin
                checks++;
                if (eng_start !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_wait_started: got %b expected 1", eng_start);
                end
            end
            if (c == 6) begin
                checks++;
                if ({res_valid, res_timeout, eng_start, eng_reset, req_ready} !== 5'b00011) begin
                    failures++;
                    $display("FAIL rst_wait_flags: got vld=%b to=%b start=%b eng_rst=%b rdy=%b expected 0 0 0 1 1",
                             res_valid, res_timeout, eng_start, eng_reset, req_ready);
                end
                checks++;
                if ({res_gcd, eng_in1, eng_in2} !== '0) begin
                    failures++;
                    $display("FAIL rst_wait_data: got gcd=%0d in1=%0d in2=%0d expected all 0", res_gcd, eng_in1, eng_in2);
                end
            end
            if (c >= 7) begin
                checks++;
                if ({res_valid, eng_start, eng_reset, req_ready} !== 4'b0001) begin
                    failures++;
                    $display("FAIL rst_wait_quiet c=%0d: got vld=%b start=%b eng_rst=%b rdy=%b expected 0 0 0 1",
                             c, res_valid, eng_start, eng_reset, req_ready);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_random();
        logic [2*W-1:0] issue_q[$];
        logic [W:0]     exp_q[$];
        logic [2*W-1:0] iss;
        logic [W:0]     ex;
        logic [W-1:0]   a_v, b_v;
        int             k;
        eng_lat = -1;
        for (int cyc = 0; cyc < 3600 && (cyc < 3000 || exp_q.size() > 0); cyc++) begin
            k   = int'($urandom_range(1, 40));
            a_v = W'(k * int'($urandom_range(0, 1000)));
            b_v = W'(k * int'($urandom_range(0, 1000)));
            if ($urandom_range(0, 7) == 0) a_v = '0;
            if ($urandom_range(0, 7) == 0) b_v = '0;
            req_valid = (cyc < 3000) && ($urandom_range(0, 9) < 6);
            req_a     = a_v;
            req_b     = b_v;
            res_ready = (cyc >= 3000) || ($urandom_range(0, 9) < 7);
            if (req_valid && req_ready) begin
                exp_q.push_back({1'b0, ref_gcd(a_v, b_v)});
                if (a_v != 0 && b_v != 0) issue_q.push_back({a_v, b_v});
            end
            if (eng_start) begin
                checks++;
                iss = (issue_q.size() > 0) ? issue_q.pop_front() : '1;
                if ({eng_in1, eng_in2} !== iss) begin
                    failures++;
                    $display("FAIL rnd_issue cyc=%0d: got in1=%0d in2=%0d expected in1=%0d in2=%0d",
                             cyc, eng_in1, eng_in2, iss[2*W-1:W], iss[W-1:0]);
                end
            end
            if (res_valid && res_ready) begin
                checks++;
                ex = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if ({res_timeout, res_gcd} !== ex) begin
                    failures++;
                    $display("FAIL rnd_result cyc=%0d: got to=%b gcd=%0d expected to=%b gcd=%0d",
                             cyc, res_timeout, res_gcd, ex[W], ex[W-1:0]);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || issue_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain: got %0d results and %0d issues outstanding expected 0 0",
                     exp_q.size(), issue_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        test_reset();
        test_basic();
        test_zero_bypass();
        test_back_pressure();
        test_watchdog();
        test_tie();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
